// File: rtl/cmp_share_arbiter.sv
// Round-robin front end that time-shares one combinational comparator among NREQ
// requesters and returns each result one cycle later on a single tagged response channel.
module cmp_share_arbiter #(
   parameter int DATA_W = 64,
   parameter int NREQ   = 2,
   parameter int OP_W   = 3,
   parameter int ID_W   = $clog2(NREQ)
) (
   input  logic                   i_clk,
   input  logic                   i_rst,
   input  logic                   i_flush,
   input  logic [NREQ-1:0]        i_req_valid,
   output logic [NREQ-1:0]        o_req_ready,
   input  logic [NREQ*DATA_W-1:0] i_req_a,
   input  logic [NREQ*DATA_W-1:0] i_req_b,
   input  logic [NREQ*OP_W-1:0]   i_req_op,
   output logic [DATA_W-1:0]      o_cmp_a,
   output logic [DATA_W-1:0]      o_cmp_b,
   output logic [OP_W-1:0]        o_cmp_op,
   input  logic                   i_cmp_res,
   output logic                   o_resp_valid,
   output logic [ID_W-1:0]        o_resp_id,
   output logic                   o_resp_res,
   input  logic                   i_resp_ready,
   output logic [15:0]            o_conflict_cnt
);

   localparam logic [ID_W:0]   NREQ_W = (ID_W+1)'(NREQ);
   localparam logic [ID_W-1:0] LAST_ID = ID_W'(NREQ-1);

   logic              r_resp_valid;
   logic [ID_W-1:0]   r_resp_id;
   logic              r_resp_res;
   logic [ID_W-1:0]   r_rr_ptr;
   logic [15:0]       r_conflict_cnt;

   logic              w_can_accept;
   logic              w_any;
   logic              w_fire;
   logic              w_contended;
   logic [ID_W-1:0]   w_gnt_id;
   logic [ID_W-1:0]   w_rr_next;
   logic [ID_W:0]     w_rot_sum [NREQ];
   logic [ID_W-1:0]   w_rot_idx [NREQ];
   logic [DATA_W-1:0] w_slice_a [NREQ];
   logic [DATA_W-1:0] w_slice_b [NREQ];
   logic [OP_W-1:0]   w_slice_op [NREQ];

   // Candidate k is the requester k positions above the round-robin pointer, wrapped mod NREQ.
   genvar gi;
   generate
      for (gi = 0; gi < NREQ; gi++) begin : g_req
         assign w_rot_sum[gi]  = {1'b0, r_rr_ptr} + (ID_W+1)'(gi);
         assign w_rot_idx[gi]  = (w_rot_sum[gi] >= NREQ_W) ? ID_W'(w_rot_sum[gi] - NREQ_W)
                                                           : ID_W'(w_rot_sum[gi]);
         assign w_slice_a[gi]  = i_req_a[gi*DATA_W +: DATA_W];
         assign w_slice_b[gi]  = i_req_b[gi*DATA_W +: DATA_W];
         assign w_slice_op[gi] = i_req_op[gi*OP_W +: OP_W];
         assign o_req_ready[gi] = w_fire && (w_gnt_id == ID_W'(gi));
      end
   endgenerate

   // Scan from the far end so the candidate nearest the pointer wins.
   always_comb begin
      w_any    = 1'b0;
      w_gnt_id = '0;
      for (int k = NREQ-1; k >= 0; k--) begin
         if (i_req_valid[w_rot_idx[k]]) begin
            w_any    = 1'b1;
            w_gnt_id = w_rot_idx[k];
         end
      end
   end

   assign w_can_accept = !i_flush && !i_rst && (!r_resp_valid || i_resp_ready);
   assign w_fire       = w_can_accept && w_any;
   assign w_rr_next    = (w_gnt_id == LAST_ID) ? '0 : w_gnt_id + ID_W'(1);
   // Clearing the lowest set bit leaves something only when two or more are set.
   assign w_contended  = |(i_req_valid & (i_req_valid - NREQ'(1)));

   assign o_cmp_a  = w_fire ? w_slice_a[w_gnt_id]  : '0;
   assign o_cmp_b  = w_fire ? w_slice_b[w_gnt_id]  : '0;
   assign o_cmp_op = w_fire ? w_slice_op[w_gnt_id] : '0;

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_resp_valid   <= 1'b0;
         r_resp_id      <= '0;
         r_resp_res     <= 1'b0;
         r_rr_ptr       <= '0;
         r_conflict_cnt <= '0;
      end else begin
         if (i_flush) begin
            r_resp_valid <= 1'b0;
         end else if (w_fire) begin
            r_resp_valid <= 1'b1;
            r_resp_id    <= w_gnt_id;
            r_resp_res   <= i_cmp_res;
            r_rr_ptr     <= w_rr_next;
         end else if (i_resp_ready) begin
            r_resp_valid <= 1'b0;
         end
         if (!i_flush && w_contended && (r_conflict_cnt != 16'hFFFF)) begin
            r_conflict_cnt <= r_conflict_cnt + 16'd1;
         end
      end
   end

   assign o_resp_valid   = r_resp_valid;
   assign o_resp_id      = r_resp_id;
   assign o_resp_res     = r_resp_res;
   assign o_conflict_cnt = r_conflict_cnt;

endmodule
